// File: rtl/flopr_async_n_if.sv
// Data bundle for flopr_async_n: the next-state value and the registered value.
// The producer drives d and observes q; the register consumes d and drives q.
interface flopr_async_n_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;

   modport master (output d, input q);
   modport slave  (input d, output q);
endinterface

// File: rtl/flopr_async_n.sv
// D-type pipeline register with asynchronous active-low reset to RESET_VALUE.
// Used for pipeline stage registers, the PC register and similar state elements.
module flopr_async_n #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   always_comb begin
      q_d = d;
   end

   // The negedge reset term makes reset win even when it lands on a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

   reset_known_a: assert property (@(posedge clk) !$isunknown(reset))
      else $error("flopr_async_n: reset is X/Z");

endmodule

// File: tb/tb_flopr_async_n.sv
// Self-checking bench for flopr_async_n: an 8-bit default instance and a
// 32-bit instance with a non-zero reset value, checked against expected queues.
module tb_flopr_async_n;

   logic        clk;
   logic        rst8;
   logic        rst32;
   int          total;
   int          bad;
   logic [7:0]  exp8_q[$];
   logic [31:0] exp32_q[$];
   logic [7:0]  e8;
   logic [31:0] e32;

   flopr_async_n_if #(.WIDTH(8))  bus8 ();
   flopr_async_n_if #(.WIDTH(32)) bus32 ();

   flopr_async_n #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (rst8),
      .d     (bus8.d),
      .q     (bus8.q)
   );

   flopr_async_n #(.WIDTH(32), .RESET_VALUE(32'h0000_1000)) dut32 (
      .clk   (clk),
      .reset (rst32),
      .d     (bus32.d),
      .q     (bus32.q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic test_reset();
      rst8    = 1'b0;
      rst32   = 1'b0;
      bus8.d  = 8'hAA;
      bus32.d = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus8.q !== 8'h00) begin
         bad++; $display("FAIL reset_q8 got=%h exp=%h", bus8.q, 8'h00);
      end
      total++;
      if (bus32.q !== 32'h0000_1000) begin
         bad++; $display("FAIL reset_q32 got=%h exp=%h", bus32.q, 32'h0000_1000);
      end
   endtask

   task automatic test_capture();
      @(negedge clk);
      rst8 = 1'b1;
      #1;
      total++;
      if (bus8.q !== 8'h00) begin
         bad++; $display("FAIL deassert_hold got=%h exp=%h", bus8.q, 8'h00);
      end
      bus8.d = 8'b1100_1100;
      exp8_q.push_back(8'hCC);
      @(posedge clk); #1;
      e8 = exp8_q.pop_front();
      total++;
      if (bus8.q !== e8) begin
         bad++; $display("FAIL capture_cc got=%h exp=%h", bus8.q, e8);
      end
      @(negedge clk);
      bus8.d = 8'b1111_0000;
      exp8_q.push_back(8'hF0);
      @(posedge clk); #1;
      e8 = exp8_q.pop_front();
      total++;
      if (bus8.q !== e8) begin
         bad++; $display("FAIL capture_f0 got=%h exp=%h", bus8.q, e8);
      end
   endtask

   task automatic test_latency();
      #1;
      bus8.d = 8'h55;
      #1;
      total++;
      if (bus8.q !== 8'hF0) begin
         bad++; $display("FAIL latency_hold1 got=%h exp=%h", bus8.q, 8'hF0);
      end
      @(negedge clk);
      bus8.d = 8'h33;
      exp8_q.push_back(8'h33);
      #1;
      total++;
      if (bus8.q !== 8'hF0) begin
         bad++; $display("FAIL latency_hold2 got=%h exp=%h", bus8.q, 8'hF0);
      end
      @(posedge clk); #1;
      e8 = exp8_q.pop_front();
      total++;
      if (bus8.q !== e8) begin
         bad++; $display("FAIL latency_edge got=%h exp=%h", bus8.q, e8);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus8.d = 8'hAA;
      exp8_q.push_back(8'hAA);
      @(posedge clk); #1;
      e8 = exp8_q.pop_front();
      total++;
      if (bus8.q !== e8) begin
         bad++; $display("FAIL async_pre got=%h exp=%h", bus8.q, e8);
      end
      #1;
      rst8 = 1'b0;
      #1;
      total++;
      if (bus8.q !== 8'h00) begin
         bad++; $display("FAIL async_reset got=%h exp=%h", bus8.q, 8'h00);
      end
   endtask

   task automatic test_reset_dominance();
      bus8.d = 8'b1010_1010;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++;
         if (bus8.q !== 8'h00) begin
            bad++; $display("FAIL dominance[%0d] got=%h exp=%h", i, bus8.q, 8'h00);
         end
         bus8.d = ~bus8.d;
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      rst8   = 1'b1;
      bus8.d = 8'hF0;
      exp8_q.push_back(8'hF0);
      @(posedge clk); #1;
      e8 = exp8_q.pop_front();
      total++;
      if (bus8.q !== e8) begin
         bad++; $display("FAIL mid_pre got=%h exp=%h", bus8.q, e8);
      end
      @(negedge clk);
      rst8 = 1'b0;
      #1;
      total++;
      if (bus8.q !== 8'h00) begin
         bad++; $display("FAIL mid_assert got=%h exp=%h", bus8.q, 8'h00);
      end
      @(posedge clk); #1;
      total++;
      if (bus8.q !== 8'h00) begin
         bad++; $display("FAIL mid_held got=%h exp=%h", bus8.q, 8'h00);
      end
      @(negedge clk);
      rst8 = 1'b1;
      #1;
      total++;
      if (bus8.q !== 8'h00) begin
         bad++; $display("FAIL mid_release got=%h exp=%h", bus8.q, 8'h00);
      end
      bus8.d = 8'b0000_1111;
      exp8_q.push_back(8'h0F);
      @(posedge clk); #1;
      e8 = exp8_q.pop_front();
      total++;
      if (bus8.q !== e8) begin
         bad++; $display("FAIL mid_capture got=%h exp=%h", bus8.q, e8);
      end
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      bus8.d = 8'h77;
      @(posedge clk);
      rst8 = 1'b0;
      #1;
      total++;
      if (bus8.q !== 8'h00) begin
         bad++; $display("FAIL simultaneous got=%h exp=%h", bus8.q, 8'h00);
      end
      @(negedge clk);
      rst8 = 1'b1;
   endtask

   task automatic test_params();
      bus32.d = 32'h1234_5678;
      @(posedge clk); #1;
      total++;
      if (bus32.q !== 32'h0000_1000) begin
         bad++; $display("FAIL param_reset got=%h exp=%h", bus32.q, 32'h0000_1000);
      end
      @(negedge clk);
      rst32   = 1'b1;
      bus32.d = 32'hDEAD_BEEF;
      exp32_q.push_back(32'hDEAD_BEEF);
      @(posedge clk); #1;
      e32 = exp32_q.pop_front();
      total++;
      if (bus32.q !== e32) begin
         bad++; $display("FAIL param_capture got=%h exp=%h", bus32.q, e32);
      end
      rst32 = 1'b0;
      #1;
      total++;
      if (bus32.q !== 32'h0000_1000) begin
         bad++; $display("FAIL param_async got=%h exp=%h", bus32.q, 32'h0000_1000);
      end
      @(negedge clk);
      rst32 = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus8.d  = 8'($urandom);
         bus32.d = $urandom;
         exp8_q.push_back(bus8.d);
         exp32_q.push_back(bus32.d);
         @(posedge clk); #1;
         e8  = exp8_q.pop_front();
         e32 = exp32_q.pop_front();
         total++;
         if (bus8.q !== e8) begin
            bad++; $display("FAIL b2b_q8[%0d] got=%h exp=%h", i, bus8.q, e8);
         end
         total++;
         if (bus32.q !== e32) begin
            bad++; $display("FAIL b2b_q32[%0d] got=%h exp=%h", i, bus32.q, e32);
         end
      end
      total++;
      if (exp8_q.size() + exp32_q.size() !== 0) begin
         bad++; $display("FAIL scoreboard_drain got=%0d exp=0", exp8_q.size() + exp32_q.size());
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst8    = 1'b0;
      rst32   = 1'b0;
      bus8.d  = '0;
      bus32.d = '0;
      test_reset();
      test_capture();
      test_latency();
      test_async_reset();
      test_reset_dominance();
      test_reset_midstream();
      test_simultaneous();
      test_params();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
